// File: rtl/config_frame_loader.sv
// Configuration word stream loader: finds the sync word, decodes frame headers
// and drives frame data, row select and a one-cycle strobe into the frame latches.
module config_frame_loader #(
    parameter int          FrameBitsPerRow = 32,
    parameter int          MaxFramesPerCol = 20,
    parameter int          NumberOfRows    = 16,
    parameter int          RowSelectWidth  = 5,
    parameter int          DesyncFlag      = 20,
    parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [FrameBitsPerRow-1:0] WriteData,
    input  logic                       WriteStrobe,
    input  logic                       FSM_Reset,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic                       FrameStrobe,
    output logic [RowSelectWidth-1:0]  RowSelect,
    output logic                       ConfigActive,
    output logic                       HeaderError
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
    } state_t;

    localparam logic [4:0]              MAX_FRAMES = 5'(MaxFramesPerCol);
    localparam logic [RowSelectWidth:0] ROW_LIMIT  = (RowSelectWidth + 1)'(NumberOfRows);

    state_t                    state;
    logic [4:0]                frame_count;

    logic [RowSelectWidth-1:0] hdr_row;
    logic [4:0]                hdr_frames;
    logic                      hdr_desync;
    logic                      hdr_is_sync;
    logic                      hdr_illegal;

    // Header fields are decoded straight off the incoming word.
    always_comb begin
        hdr_row     = WriteData[RowSelectWidth-1:0];
        hdr_frames  = WriteData[12:8];
        hdr_desync  = WriteData[DesyncFlag];
        hdr_is_sync = (WriteData == SyncWord);
        hdr_illegal = (hdr_frames == 5'd0) || (hdr_frames > MAX_FRAMES)
                      || ({1'b0, hdr_row} >= ROW_LIMIT);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            frame_count  <= '0;
            FrameData    <= '0;
            FrameStrobe  <= 1'b0;
            RowSelect    <= '0;
            ConfigActive <= 1'b0;
            HeaderError  <= 1'b0;
        end else if (FSM_Reset) begin
            state        <= IDLE;
            frame_count  <= '0;
            FrameData    <= '0;
            FrameStrobe  <= 1'b0;
            RowSelect    <= '0;
            ConfigActive <= 1'b0;
            HeaderError  <= 1'b0;
        end else begin
            FrameStrobe <= 1'b0;
            if (WriteStrobe) begin
                case (state)
                    IDLE: begin
                        if (hdr_is_sync) begin
                            state        <= HEADER;
                            ConfigActive <= 1'b1;
                        end
                    end
                    HEADER: begin
                        if (hdr_is_sync) begin
                            state <= HEADER;
                        end else if (hdr_desync) begin
                            state        <= IDLE;
                            ConfigActive <= 1'b0;
                        end else if (hdr_illegal) begin
                            state        <= IDLE;
                            ConfigActive <= 1'b0;
                            HeaderError  <= 1'b1;
                        end else begin
                            state       <= DATA;
                            RowSelect   <= hdr_row;
                            frame_count <= hdr_frames;
                        end
                    end
                    DATA: begin
                        // Every word is payload here, even ones that look like sync or desync.
                        FrameData   <= WriteData;
                        FrameStrobe <= 1'b1;
                        frame_count <= frame_count - 5'd1;
                        if (frame_count == 5'd1) begin
                            state <= HEADER;
                        end
                    end
                    default: begin
                        state        <= IDLE;
                        ConfigActive <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/config_frame_loader.md
Name: config_frame_loader

Overview:
- Upstream feeder of the tile configuration chain. Accepts a 32-bit configuration word stream, typically from the USB/UART bitstream front end.
- Detects a sync word and decodes frame headers. Drives frame data, a row select and a one-cycle frame strobe into the frame-latch array. The latched bits are what the tile config-access BELs export as ConfigBits/C_bit.
- Also reports configuration-in-progress and header error status to the fabric top.

Parameters:
- FrameBitsPerRow, 32: width of FrameData and WriteData.
- MaxFramesPerCol, 20: largest legal frame count in one header.
- NumberOfRows, 16: number of addressable tile rows.
- RowSelectWidth, 5: width of RowSelect and of the header row field.
- DesyncFlag, 20: bit index in the header word that requests desync.
- SyncWord, 32'hFAB0_FAB1: pattern that starts a configuration session.

Ports:
- CLK  input  1  system clock; all state on rising edge.
- RST  input  1  asynchronous, active-high reset.
- WriteData  input  FrameBitsPerRow  incoming configuration word.
- WriteStrobe  input  1  WriteData valid this cycle; one word accepted per high cycle; no backpressure.
- FSM_Reset  input  1  synchronous soft reset, active-high.
- FrameData  output  FrameBitsPerRow  registered frame word for the frame latches.
- FrameStrobe  output  1  one-cycle pulse; FrameData/RowSelect valid this cycle.
- RowSelect  output  RowSelectWidth  target row of the current frame group.
- ConfigActive  output  1  high while synced (HEADER or DATA state).
- HeaderError  output  1  sticky flag: an illegal header was received.

Behaviour:
- Reset is asynchronous, active-high on RST. On reset: state=IDLE, FrameData=0, FrameStrobe=0, RowSelect=0, ConfigActive=0, HeaderError=0, frame counter=0.
- Header word fields:
  - [RowSelectWidth-1:0] = row.
  - [12:8] = frame count N.
  - [DesyncFlag] = desync request.
  - All other bits are ignored.
- States:
  - IDLE:
    - Strobed word == SyncWord -> HEADER; ConfigActive=1 from the next cycle.
    - Any other strobed word is discarded silently.
  - HEADER (strobed word):
    - Word == SyncWord: re-sync, stay in HEADER, no outputs change.
    - Else if desync bit is set: -> IDLE, ConfigActive=0 next cycle. Other fields are ignored.
    - Else if N==0, N>MaxFramesPerCol, or row>=NumberOfRows: HeaderError=1 (sticky), -> IDLE, ConfigActive=0.
    - Else: RowSelect<=row, counter<=N, -> DATA.
  - DATA (strobed word):
    - FrameData<=WriteData and FrameStrobe=1 in the following cycle. Latency is exactly 1 cycle from accept to strobe.
    - Counter decrements on each word. On the word that makes the counter 0, the next state is HEADER.
    - SyncWord and desync-bit words are plain data here; they are not interpreted.
- FrameStrobe is high only in the cycle after an accepted DATA word. Back-to-back strobes give back-to-back pulses.
- FrameData holds its value between words.
- RowSelect holds its value until the next legal header, including through IDLE.
- WriteStrobe low: no state change; FrameStrobe deasserts.
- FSM_Reset: takes priority over WriteStrobe in the same cycle. Next cycle gives the full reset values, including HeaderError cleared. The word presented in that cycle is discarded.
- RST or FSM_Reset in the middle of a frame group discards the remainder. Frames already strobed are not undone.
- Only HeaderError is sticky. A legal sync does not clear it; only RST or FSM_Reset clears it.

Test Plan:
- Sync 0xFAB0FAB1, header row=3 N=2, data 0xDEADBEEF then 0x12345678 on consecutive cycles -> two consecutive FrameStrobe pulses, each 1 cycle after its word. RowSelect=3. FrameData shows 0xDEADBEEF, then 0x12345678. State returns to HEADER with ConfigActive=1.
- Header with bit 20 set after sync -> ConfigActive falls next cycle. A following data word produces no FrameStrobe.
- Illegal headers, applied separately: N=0; N=21; row=16 -> each sets HeaderError=1 and returns to IDLE. HeaderError stays 1 across a new legal sync and frame group.
- In DATA with N=3, send SyncWord as the 2nd word -> it is strobed as FrameData=0xFAB0FAB1. The counter continues; the 3rd word completes the group.
- RST asserted asynchronously mid-group, with WriteStrobe gaps between words -> all outputs are 0 immediately. Words sent after release without a sync are ignored.
- FSM_Reset and WriteStrobe high together in DATA -> word discarded, no FrameStrobe, HeaderError cleared, state IDLE.
